// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Shares one DATA_W-bit adder between NUM_REQ requesters. A round-robin
//   arbiter picks one valid requester per cycle. The sum and carry of the
//   picked request are registered into a one-entry output slot, together
//   with the requester index. The slot can drain and refill in the same
//   cycle, so the block sustains one operation per clock.
//
//   Ports
//     clk        clock, rising edge
//     rst        synchronous reset, active high
//     req_valid  [NUM_REQ]          per-requester request valid
//     req_ready  [NUM_REQ]          per-requester accept (one-hot or zero)
//     req_a      [NUM_REQ*DATA_W]   operand A, requester i at [i*DATA_W +: DATA_W]
//     req_b      [NUM_REQ*DATA_W]   operand B, same packing
//     res_valid                     output slot holds a result
//     res_ready                     consumer takes the result
//     res_sum    [DATA_W]           (a+b) mod 2^DATA_W
//     res_carry                     carry out of the sum
//     res_id     [ID_W]             index of the producing requester
//     busy                          result pending or any request valid
//     op_count   [16]               accepted-operation counter
//
//   Build option
//     ADDER_ARBITER_STATS_EN : when defined, op_count counts accepts and
//     saturates at 16'hFFFF. When undefined, op_count is tied to zero and
//     no counter flops exist.
module adder_arbiter #(
   parameter int  NUM_REQ = 4,
   parameter int  DATA_W  = 8,
   localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [DATA_W-1:0]         res_sum,
   output logic                      res_carry,
   output logic [ID_W-1:0]           res_id,
   output logic                      busy,
   output logic [15:0]               op_count
);

   logic [NUM_REQ-1:0][DATA_W-1:0] a_arr, b_arr;
   logic [ID_W-1:0]                last_grant;
   logic [ID_W-1:0]                grant;
   logic [ID_W-1:0]                cand;
   logic                           grant_found;
   logic                           slot_free;
   logic                           accept;
   logic [DATA_W:0]                sum_full;

   assign a_arr = req_a;
   assign b_arr = req_b;

   // Slot can take a new result when empty or when it drains this cycle.
   assign slot_free = !res_valid || res_ready;

   // Rotating search starting just above the last winner. Priority only
   // moves on an accept, so idle cycles leave the order untouched.
   always_comb begin
      grant       = '0;
      cand        = '0;
      grant_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((int'(last_grant) + 1 + k) % NUM_REQ);
         if (!grant_found && req_valid[cand]) begin
            grant       = cand;
            grant_found = 1'b1;
         end
      end
   end

   assign accept = grant_found && slot_free && !rst;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++)
         req_ready[i] = accept && (grant == ID_W'(i));
   end

   assign sum_full = {1'b0, a_arr[grant]} + {1'b0, b_arr[grant]};

   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid  <= 1'b0;
         res_sum    <= '0;
         res_carry  <= 1'b0;
         res_id     <= '0;
         last_grant <= ID_W'(NUM_REQ - 1);
      end else if (accept) begin
         // Covers the drain-and-refill case too: the slot is overwritten.
         res_valid  <= 1'b1;
         res_sum    <= sum_full[DATA_W-1:0];
         res_carry  <= sum_full[DATA_W];
         res_id     <= grant;
         last_grant <= grant;
      end else if (res_valid && res_ready) begin
         res_valid  <= 1'b0;
      end
   end

   assign busy = res_valid || (|req_valid);

`ifdef ADDER_ARBITER_STATS_EN
   logic [15:0] op_cnt_q;

   always_ff @(posedge clk) begin
      if (rst)
         op_cnt_q <= '0;
      else if (accept && (op_cnt_q != 16'hFFFF))
         op_cnt_q <= op_cnt_q + 16'd1;
   end

   assign op_count = op_cnt_q;
`else
   assign op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;
   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a, req_b;
   logic           res_valid;
   logic           res_ready;
   logic [W-1:0]   res_sum;
   logic           res_carry;
   logic [1:0]     res_id;
   logic           busy;
   logic [15:0]    op_count;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         carry;
      logic [1:0]   id;
   } res_t;

   res_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   m_last   = N - 1;
   int   m_cnt    = 0;

   adder_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_sum(res_sum), .res_carry(res_carry), .res_id(res_id),
      .busy(busy), .op_count(op_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_cnt(input int c);
`ifdef ADDER_ARBITER_STATS_EN
      return 16'(c);
`else
      return 16'(c * 0);
`endif
   endfunction

   // Scoreboard: outputs checked against queue head; the next edge is
   // predicted from the inputs, pushing a result on accept, popping on drain.
   always @(negedge clk) begin
      res_t           e;
      logic [2*N-1:0] dbl;
      logic [N-1:0]   rot, exp_rdy;
      logic [W:0]     s;
      logic [W-1:0]   a, b;
      int             g;
      logic           found, slot_free;

      chk("res_valid", 32'(res_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         e = q[0];
         chk("res_sum",   32'(res_sum),   32'(e.sum));
         chk("res_carry", 32'(res_carry), 32'(e.carry));
         chk("res_id",    32'(res_id),    32'(e.id));
      end
      chk("op_count", 32'(op_count), 32'(exp_cnt(m_cnt)));
      chk("busy", 32'(busy), 32'((q.size() != 0) || (req_valid != '0)));

      if (rst) begin
         chk("rst_ready", 32'(req_ready), 32'd0);
         q.delete();
         m_last = N - 1;
         m_cnt  = 0;
      end else begin
         dbl   = {req_valid, req_valid};
         rot   = N'(dbl >> (m_last + 1));
         found = 1'b0;
         g     = 0;
         for (int k = 0; k < N; k++)
            if (!found && rot[k]) begin
               found = 1'b1;
               g     = (m_last + 1 + k) % N;
            end
         slot_free = (q.size() == 0) || res_ready;
         exp_rdy   = (found && slot_free) ? N'(1 << g) : '0;
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         if (q.size() != 0 && res_ready) void'(q.pop_front());
         if (found && slot_free) begin
            a = req_a[g*W +: W];
            b = req_b[g*W +: W];
            s = {1'b0, a} + {1'b0, b};
            e.sum   = s[W-1:0];
            e.carry = s[W];
            e.id    = 2'(g);
            q.push_back(e);
            m_last = g;
            if (m_cnt < 65535) m_cnt++;
         end
      end
   end

   task automatic single(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] es, input logic ec);
      req_valid = 4'(1 << idx);
      req_a[idx*W +: W] = a;
      req_b[idx*W +: W] = b;
      res_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("single_valid", 32'(res_valid), 32'd1);
      chk("single_sum",   32'(res_sum),   32'(es));
      chk("single_carry", 32'(res_carry), 32'(ec));
      chk("single_id",    32'(res_id),    32'(idx));
      @(posedge clk); #1;
   endtask

   task automatic rand_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         req_valid = 4'($urandom);
         req_a     = $urandom;
         req_b     = $urandom;
         res_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 4'b1111;
      req_a     = {8'h40, 8'h30, 8'h20, 8'h10};
      req_b     = {8'h04, 8'h03, 8'h02, 8'h01};
      res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Fairness: all requesting, grants rotate 0,1,2,3,0,1 with no bubbles.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("fair_rdy", 32'(req_ready), 32'(1 << (i % 4)));
         if (i > 0) begin
            chk("fair_valid", 32'(res_valid), 32'd1);
            chk("fair_id",    32'(res_id),    32'((i - 1) % 4));
         end
      end
      @(posedge clk); #1;

      single(2, 8'h7F, 8'h01, 8'h80, 1'b0);
      single(1, 8'hFF, 8'h02, 8'h01, 1'b1);
      single(0, 8'hFF, 8'h01, 8'h00, 1'b1);

      // Backpressure: fill the slot, stall for 3 cycles, then drain+refill.
      req_valid = 4'b1000;
      req_a[3*W +: W] = 8'h10;
      req_b[3*W +: W] = 8'h20;
      res_ready = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_ready", 32'(req_ready), 32'd0);
         chk("bp_valid", 32'(res_valid), 32'd1);
         chk("bp_sum",   32'(res_sum),   32'h30);
         chk("bp_id",    32'(res_id),    32'd3);
         @(posedge clk); #1;
      end
      req_a[3*W +: W] = 8'h05;
      req_b[3*W +: W] = 8'h06;
      res_ready = 1'b1;
      @(negedge clk);
      chk("bp_refill_ready", 32'(req_ready), 32'b1000);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("bp_refill_sum", 32'(res_sum), 32'h0B);
      chk("bp_refill_id",  32'(res_id),  32'd3);
      @(posedge clk); #1;

      rand_cycles(150);

      // Reset pulse mid-stream, then exactly 5 accepts.
      rst = 1'b1;
      req_valid = 4'b1111;
      @(posedge clk); #1;
      rst = 1'b0;
      req_valid = '0;
      @(negedge clk);
      chk("rst_mid_valid", 32'(res_valid), 32'd0);
      chk("rst_mid_count", 32'(op_count),  32'd0);
      req_valid = 4'b0001;
      res_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
`ifdef ADDER_ARBITER_STATS_EN
      chk("stats_count", 32'(op_count), 32'd5);
`else
      chk("stats_count", 32'(op_count), 32'd0);
`endif
      @(posedge clk); #1;

      rand_cycles(150);
      req_valid = '0;
      res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
